// File: rtl/valu_writeback.sv
// vALU writeback stage: merges the result with the old vd contents under vl/mask/SEW, then
// buffers the merged write in a small in-order FIFO. Define VWB_TAIL_AGNOSTIC_EN for all-ones tails.
module valu_writeback #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_vd,
  input  logic [127:0] in_result,
  input  logic [127:0] in_old,
  input  logic [7:0]   in_sew,
  input  logic [7:0]   in_vl,
  input  logic [15:0]  in_mask,
  input  logic         in_vm,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [4:0]   wb_vd,
  output logic [127:0] wb_data,
  output logic         wb_err,
  output logic [31:0]  pending_vd,
  output logic [15:0]  wb_count
);

  localparam int unsigned PtrW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = PtrW + 1;

  // ---------------------------------------------------------------------------------------------
  // Merge
  // ---------------------------------------------------------------------------------------------
  logic         sew_ok;
  logic [2:0]   elem_shift;
  logic [4:0]   n_elem;
  logic [7:0]   vl_eff;
  logic [4:0]   byte_elem [16];
  logic [15:0]  byte_body;
  logic [15:0]  byte_active;
  logic [127:0] merged;

  always_comb begin
    sew_ok     = 1'b1;
    elem_shift = 3'd0;
    n_elem     = 5'd16;
    case (in_sew)
      8'd8:    begin elem_shift = 3'd0; n_elem = 5'd16; end
      8'd16:   begin elem_shift = 3'd1; n_elem = 5'd8;  end
      8'd32:   begin elem_shift = 3'd2; n_elem = 5'd4;  end
      8'd64:   begin elem_shift = 3'd3; n_elem = 5'd2;  end
      8'd128:  begin elem_shift = 3'd4; n_elem = 5'd1;  end
      default: sew_ok = 1'b0;
    endcase
    vl_eff = (in_vl > {3'b000, n_elem}) ? {3'b000, n_elem} : in_vl;
  end

  // Work per byte: byte b sits at bits [127-8b -: 8] and belongs to element b / (SEW/8).
  always_comb begin
    merged      = '0;
    byte_body   = '0;
    byte_active = '0;
    for (int b = 0; b < 16; b++) begin
      byte_elem[b]   = 5'(b) >> elem_shift;
      byte_body[b]   = ({3'b000, byte_elem[b]} < vl_eff);
      byte_active[b] = byte_body[b] && (in_vm || in_mask[byte_elem[b][3:0]]);
      if (!sew_ok || (byte_body[b] && !byte_active[b])) begin
        merged[127-8*b -: 8] = in_old[127-8*b -: 8];
      end else if (byte_active[b]) begin
        merged[127-8*b -: 8] = in_result[127-8*b -: 8];
      end else begin
`ifdef VWB_TAIL_AGNOSTIC_EN
        merged[127-8*b -: 8] = 8'hFF;
`else
        merged[127-8*b -: 8] = in_old[127-8*b -: 8];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  logic [4:0]       vd_q   [DEPTH];
  logic [127:0]     data_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [31:0]      pending_q, pending_d;
  logic [15:0]      wb_count_q;
  logic             push, pop;

  assign in_ready = (count_q < CntW'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;

  assign wb_vd      = vd_q[rd_ptr_q];
  assign wb_data    = data_q[rd_ptr_q];
  assign wb_err     = err_q[rd_ptr_q];
  assign pending_vd = pending_q;
  assign wb_count   = wb_count_q;

  // Pending set is rebuilt from the post-edge slot contents so it tracks push/pop exactly.
  always_comb begin
    count_d   = count_q;
    valid_d   = valid_q;
    pending_d = '0;
    if (push && !pop) count_d = count_q + CntW'(1);
    if (pop && !push) count_d = count_q - CntW'(1);
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (valid_d[k]) begin
        if (push && (wr_ptr_q == PtrW'(k))) begin
          pending_d = pending_d | (32'd1 << in_vd);
        end else begin
          pending_d = pending_d | (32'd1 << vd_q[k]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        vd_q[k]   <= '0;
        data_q[k] <= '0;
      end
      err_q      <= '0;
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      wb_count_q <= '0;
    end else begin
      if (push) begin
        vd_q[wr_ptr_q]   <= in_vd;
        data_q[wr_ptr_q] <= merged;
        err_q[wr_ptr_q]  <= ~sew_ok;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        wb_count_q <= wb_count_q + 16'd1;
      end
      valid_q   <= valid_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_valu_writeback.sv
// Directed self-checking bench for valu_writeback (DEPTH = 2); honours VWB_TAIL_AGNOSTIC_EN.
module tb_valu_writeback;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_vd;
  logic [127:0] in_result;
  logic [127:0] in_old;
  logic [7:0]   in_sew;
  logic [7:0]   in_vl;
  logic [15:0]  in_mask;
  logic         in_vm;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_vd;
  logic [127:0] wb_data;
  logic         wb_err;
  logic [31:0]  pending_vd;
  logic [15:0]  wb_count;

  int errors = 0;
  int checks = 0;

  valu_writeback #(.DEPTH(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vd      (in_vd),
    .in_result  (in_result),
    .in_old     (in_old),
    .in_sew     (in_sew),
    .in_vl      (in_vl),
    .in_mask    (in_mask),
    .in_vm      (in_vm),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_vd      (wb_vd),
    .wb_data    (wb_data),
    .wb_err     (wb_err),
    .pending_vd (pending_vd),
    .wb_count   (wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] vd, input logic [127:0] res, input logic [127:0] old,
                      input logic [7:0] sew, input logic [7:0] vl, input logic [15:0] mask,
                      input logic vm);
    in_vd     = vd;
    in_result = res;
    in_old    = old;
    in_sew    = sew;
    in_vl     = vl;
    in_mask   = mask;
    in_vm     = vm;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] ResA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] OldA = 128'hCAFE_BABE_DEAD_BEEF_0BAD_F00D_1357_9BDF;
  localparam logic [127:0] ResB = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;

  logic [127:0] exp_tail;
  logic [127:0] exp_sew128;
  int pushes;
  int pops;
  int guard;
  logic push_fire;
  logic pop_fire;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    wb_ready  = 1'b0;
    in_vd     = '0;
    in_result = '0;
    in_old    = '0;
    in_sew    = '0;
    in_vl     = '0;
    in_mask   = '0;
    in_vm     = 1'b0;
`ifdef VWB_TAIL_AGNOSTIC_EN
    exp_tail   = 128'h1111_1111_1111_FFFF_FFFF_FFFF_FFFF_FFFF;
    exp_sew128 = '1;
`else
    exp_tail   = 128'h1111_1111_1111_AAAA_AAAA_AAAA_AAAA_AAAA;
    exp_sew128 = OldA;
`endif

    // Reset state
    #12;
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_wb_vd", wb_vd, 0);
    check_eq("rst_wb_err", wb_err, 0);
    check_eq("rst_pending", pending_vd, 0);
    check_eq("rst_wb_count", wb_count, 0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_in_ready", in_ready, 1);

    // Tail handling, SEW=16 vl=3, one-cycle latency
    push(5'd5, {8{16'h1111}}, {8{16'hAAAA}}, 8'd16, 8'd3, 16'h0000, 1'b1);
    check_eq("tail_latency", wb_valid, 1);
    check_eq("tail_data", wb_data, exp_tail);
    check_eq("tail_vd", wb_vd, 5);
    check_eq("tail_err", wb_err, 0);
    check_eq("tail_pending", pending_vd, 32'h0000_0020);
    pop_one();
    check_eq("tail_drained", wb_valid, 0);
    check_eq("tail_pending_clr", pending_vd, 0);
    check_eq("tail_count", wb_count, 1);

    // Mask merge, SEW=32
    push(5'd9, {4{32'h1111_1111}}, {4{32'h2222_2222}}, 8'd32, 8'd4, 16'h0005, 1'b0);
    check_eq("mask_data", wb_data,
             {32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222});
    pop_one();

    // SEW=128 with vl=0: whole register is tail
    push(5'd1, ResA, OldA, 8'd128, 8'd0, 16'hFFFF, 1'b1);
    check_eq("sew128_vl0_data", wb_data, exp_sew128);
    pop_one();

    // Illegal SEW
    push(5'd2, ResA, OldA, 8'd12, 8'd4, 16'hFFFF, 1'b1);
    check_eq("bad_sew_err", wb_err, 1);
    check_eq("bad_sew_data", wb_data, OldA);
    pop_one();

    // vl beyond N at SEW=8: all elements active
    push(5'd3, ResA, OldA, 8'd8, 8'd200, 16'h0000, 1'b1);
    check_eq("vl_clamp_data", wb_data, ResA);
    check_eq("vl_clamp_err", wb_err, 0);
    pop_one();
    check_eq("count_5", wb_count, 5);

    // Simultaneous push and pop keeps occupancy
    push(5'd4, ResA, OldA, 8'd8, 8'd16, 16'h0000, 1'b1);
    wb_ready = 1'b1;
    push(5'd6, ResB, OldA, 8'd8, 8'd16, 16'h0000, 1'b1);
    wb_ready = 1'b0;
    check_eq("pushpop_valid", wb_valid, 1);
    check_eq("pushpop_vd", wb_vd, 6);
    check_eq("pushpop_pending", pending_vd, 32'h0000_0040);
    pop_one();
    check_eq("pushpop_empty", wb_valid, 0);

    // Backpressure with DEPTH=2
    do_reset();
    push(5'd3, ResA, OldA, 8'd8, 8'd16, 16'h0000, 1'b1);
    push(5'd7, ResB, OldA, 8'd8, 8'd16, 16'h0000, 1'b1);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_pending", pending_vd, 32'h0000_0088);
    check_eq("bp_head_vd", wb_vd, 3);
    in_vd     = 5'd12;
    in_result = OldA;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_hold_data", wb_data, ResA);
    check_eq("bp_hold_vd", wb_vd, 3);
    check_eq("bp_hold_pending", pending_vd, 32'h0000_0088);
    pop_one();
    check_eq("bp_second_vd", wb_vd, 7);
    check_eq("bp_second_data", wb_data, ResB);
    check_eq("bp_ready_again", in_ready, 1);
    check_eq("bp_pending_7", pending_vd, 32'h0000_0080);
    pop_one();
    check_eq("bp_empty", wb_valid, 0);
    check_eq("bp_count", wb_count, 2);

    // Reset with two entries buffered
    push(5'd10, ResA, OldA, 8'd8, 8'd16, 16'h0000, 1'b1);
    push(5'd11, ResB, OldA, 8'd8, 8'd16, 16'h0000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", wb_valid, 0);
    check_eq("mid_rst_pending", pending_vd, 0);
    check_eq("mid_rst_count", wb_count, 0);
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wb_ready = 1'b0;
    check_eq("post_rst_valid", wb_valid, 0);
    check_eq("post_rst_count", wb_count, 0);

    // Counter wrap after 65536 pops
    pushes = 0;
    pops   = 0;
    guard  = 0;
    in_sew = 8'd8;
    in_vl  = 8'd16;
    in_vm  = 1'b1;
    while (pops < 65536 && guard < 70000) begin
      in_valid  = (pushes < 65536);
      wb_ready  = 1'b1;
      push_fire = in_valid && in_ready;
      pop_fire  = wb_valid && wb_ready;
      @(posedge clk);
      #1;
      if (push_fire) pushes++;
      if (pop_fire) pops++;
      guard++;
      if (pop_fire && pops == 65535) check_eq("count_ffff", wb_count, 16'hFFFF);
    end
    in_valid = 1'b0;
    wb_ready = 1'b0;
    check_eq("wrap_pops", pops, 65536);
    check_eq("wrap_count", wb_count, 0);
    check_eq("wrap_empty", wb_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/valu_writeback.md
VALU_WRITEBACK -- requirements
Module: valu_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning writeback FIFO entries (legal values 2 and 4).
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  vALU result presented.
REQ-005 SHALL have port: in_ready  output  1  stage can accept.
REQ-006 SHALL have port: in_vd  input  5  destination vector register index.
REQ-007 SHALL have port: in_result  input  128  vALU reg_dest.
REQ-008 SHALL have port: in_old  input  128  prior contents of vd.
REQ-009 SHALL have port: in_sew  input  8  element width in bits (8/16/32/64/128).
REQ-010 SHALL have port: in_vl  input  8  active vector length, in elements.
REQ-011 SHALL have port: in_mask  input  16  per-element mask, bit i = element i.
REQ-012 SHALL have port: in_vm  input  1  1 = unmasked operation.
REQ-013 SHALL have port: wb_valid  output  1  write to register file valid.
REQ-014 SHALL have port: wb_ready  input  1  register file accepts.
REQ-015 SHALL have port: wb_vd  output  5  write index.
REQ-016 SHALL have port: wb_data  output  128  merged write data.
REQ-017 SHALL have port: wb_err  output  1  entry carried illegal SEW.
REQ-018 SHALL have port: pending_vd  output  32  bit r set while any buffered entry targets register r.
REQ-019 SHALL have port: wb_count  output  16  completed writebacks.

Function
REQ-020 Element i SHALL occupy bits [127-i*SEW -: SEW], so element 0 is the MSB end; element count N = 128/SEW.
REQ-021 Effective vl SHALL be min(in_vl, N); element i is active when i < vl and (in_vm or in_mask[i]).
REQ-022 Active elements SHALL take in_result; masked-off body elements SHALL take in_old (undisturbed).
REQ-023 Tail elements (i >= vl) SHALL follow REQ-035/036.
REQ-024 Illegal in_sew (not 8/16/32/64/128) SHALL enqueue wb_data = in_old with wb_err = 1.
REQ-025 Merge SHALL be computed at acceptance and stored; a transfer SHALL occur when in_valid and in_ready are both high at clk.
REQ-026 in_ready SHALL equal (occupancy < DEPTH); there SHALL be no combinational path from wb_ready to in_ready.
REQ-027 Latency SHALL be one cycle: an entry accepted at edge N into an empty FIFO shows wb_valid = 1 after edge N.
REQ-028 wb_valid SHALL equal (occupancy > 0); the head SHALL pop when wb_valid and wb_ready are both high at clk; entries leave in order.
REQ-029 wb_vd/wb_data/wb_err SHALL be held stable while wb_valid = 1 and wb_ready = 0.
REQ-030 Simultaneous push and pop SHALL leave occupancy unchanged; push while full cannot occur (in_ready = 0).
REQ-031 pending_vd SHALL be the OR of one-hot(vd) over all valid entries, registered and updated on the same edge as push/pop.
REQ-032 wb_count SHALL increment on each pop and wrap from 0xFFFF to 0x0000.

Reset
REQ-033 On rst_n = 0, asynchronously: occupancy = 0, wb_valid = 0, in_ready = 1 only after release, wb_vd = 0, wb_data = 0, wb_err = 0, pending_vd = 0, wb_count = 0.
REQ-034 Reset mid-operation SHALL discard all buffered entries without issuing a writeback.

Configuration
REQ-035 With VWB_TAIL_AGNOSTIC_EN defined, tail elements SHALL be written all-ones (tail-agnostic).
REQ-036 Without VWB_TAIL_AGNOSTIC_EN, tail elements SHALL take in_old (tail-undisturbed).

Verification
REQ-037 Tail handling: SEW=16, vl=3, vm=1, result=all 0x1111, old=all 0xAAAA -> wb_data = 0x1111_1111_1111_AAAA_AAAA_AAAA_AAAA_AAAA; with the macro, the tail is 0xFFFF.
REQ-038 Mask merge: SEW=32, vl=4, vm=0, mask=0b0101, result=0x11..., old=0x22... -> elements 0 and 2 = 0x11111111, elements 1 and 3 = 0x22222222.
REQ-039 Backpressure: wb_ready = 0, push 3 entries with DEPTH=2 -> in_ready low after 2 entries; data stable; pending_vd shows both vd values; release -> in-order pops, wb_count = 2.
REQ-040 Edge cases: SEW=128 with vl=0 -> wb_data = old (tail); SEW=12 -> wb_err = 1 and wb_data = old; vl=200 at SEW=8 -> all 16 elements active.
REQ-041 Reset with 2 entries buffered -> wb_valid = 0 and pending_vd = 0 immediately; no writeback after release.
REQ-042 Counter wrap: preload via 65536 pops -> wb_count returns to 0x0000.
